// File: rtl/star_pkg.sv
// Shared definitions for the STAR softmax blocks: row geometry, default
// fraction width, normaliser FSM states and the normaliser result entry.
package star_pkg;

  localparam int Input_len = 32;
  localparam int LUT_len   = 256;
  localparam int Q_W_DEF   = 16;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PUSH = 2'd2
  } norm_state_t;

  typedef struct packed {
    logic [Q_W_DEF-1:0] prob;
    logic [IDX_W-1:0]   idx;
  } norm_entry_t;

endpackage

// File: rtl/star_norm_fifo.sv
// Small synchronous FIFO for normaliser results. Extra pointer MSB tells
// full from empty; head is read straight out of registered storage.
module star_norm_fifo
  import star_pkg::*;
#(
  parameter int W     = Q_W_DEF + IDX_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // storage write; data is not reset, only pointers are
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // read/write pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/star_softmax_norm.sv
// STAR softmax normaliser: prob = exp / sum_exp as an unsigned Q0.Q_W
// fraction from a bit-serial restoring divider, buffered in a small FIFO
// with element index and end-of-row flag.
// Optional build macro STAR_NORM_ROUND_EN: one extra quotient bit and
// round-half-up with saturation (one extra cycle of latency).
module star_softmax_norm
  import star_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int Q_W        = Q_W_DEF,
  parameter int N_ELEM     = Input_len,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] exp,
  input  logic [DATA_W-1:0] sum_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Q_W-1:0]    prob,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              div_zero,
  output logic              row_done
);

`ifdef STAR_NORM_ROUND_EN
  localparam int QX_W = Q_W + 1;
`else
  localparam int QX_W = Q_W;
`endif
  localparam int                CNT_W    = $clog2(QX_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(QX_W - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam int                ENTRY_W  = Q_W + IDX_W;

  // Map the raw quotient onto the Q_W-bit result; the rounding build adds
  // the guard bit and clamps at all-ones instead of wrapping to zero.
  function automatic logic [Q_W-1:0] finish_quot(input logic [QX_W-1:0] q);
`ifdef STAR_NORM_ROUND_EN
    logic [Q_W:0] rnd;
    rnd = {1'b0, q[QX_W-1:1]} + {{Q_W{1'b0}}, q[0]};
    return rnd[Q_W] ? {Q_W{1'b1}} : rnd[Q_W-1:0];
`else
    return q;
`endif
  endfunction

  norm_state_t        state;
  norm_state_t        state_nxt;
  logic [DATA_W:0]    rem;
  logic [DATA_W:0]    rem_shl;
  logic [DATA_W:0]    rem_sub;
  logic               rem_ge;
  logic [DATA_W-1:0]  sum_q;
  logic [QX_W-1:0]    quot;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   idx_cnt;
  logic               accept;
  logic               fast;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;

  assign accept  = in_valid && in_ready;
  assign fast    = (sum_exp == '0) || (exp == '0) || (exp >= sum_exp);
  assign pop     = out_valid && out_ready;
  assign rem_shl = rem << 1;
  assign rem_ge  = (rem_shl >= {1'b0, sum_q});
  assign rem_sub = rem_shl - {1'b0, sum_q};

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? PUSH : DIV;
      DIV:     if (bit_cnt == LAST_BIT) state_nxt = PUSH;
      PUSH:    if (push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; a full FIFO still takes the write when its head leaves
  always_comb begin
    in_ready = (state == IDLE) && reset;
    push     = (state == PUSH) && (!full || pop);
  end

  // divider datapath; fast paths preload a quotient that finishes to 0 or all-ones
  always_ff @(posedge clk) begin
    if (accept) begin
      rem     <= {1'b0, exp};
      sum_q   <= sum_exp;
      bit_cnt <= '0;
      if ((sum_exp == '0) || (exp >= sum_exp)) quot <= '1;
      else                                     quot <= '0;
    end else if (state == DIV) begin
      rem     <= rem_ge ? rem_sub : rem_shl;
      quot    <= {quot[QX_W-2:0], rem_ge};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // element index, advanced on every FIFO write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    idx_cnt <= '0;
    else if (push) idx_cnt <= (idx_cnt == LAST_IDX) ? '0 : idx_cnt + 1'b1;
  end

  // sticky divide-by-zero flag and end-of-row pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_zero <= 1'b0;
      row_done <= 1'b0;
    end else begin
      if (accept && (sum_exp == '0)) div_zero <= 1'b1;
      row_done <= pop && out_last;
    end
  end

  star_norm_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({finish_quot(quot), idx_cnt}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign prob      = out_valid ? head[ENTRY_W-1:IDX_W] : '0;
  assign out_idx   = out_valid ? head[IDX_W-1:0] : '0;
  assign out_last  = out_valid && (out_idx == LAST_IDX);

endmodule

// File: tb/tb_star_softmax_norm.sv
// Bench for star_softmax_norm: directed and random pairs, expected
// probabilities from exact integer arithmetic, checked by a scoreboard.
module tb_star_softmax_norm;

  localparam int DATA_W = 32;
  localparam int Q_W    = 16;
  localparam int N_ELEM = 32;
`ifdef STAR_NORM_ROUND_EN
  localparam int DIV_LAT = Q_W + 2;
  localparam logic [15:0] TWO_THIRDS = 16'hAAAB;
`else
  localparam int DIV_LAT = Q_W + 1;
  localparam logic [15:0] TWO_THIRDS = 16'hAAAA;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] exp_in = '0;
  logic [DATA_W-1:0] sum_in = '0;
  logic              in_ready, out_valid, out_last, div_zero, row_done;
  logic [Q_W-1:0]    prob;
  logic [4:0]        out_idx;

  star_softmax_norm #(.DATA_W(DATA_W), .Q_W(Q_W), .N_ELEM(N_ELEM), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .exp(exp_in), .sum_exp(sum_in), .out_valid(out_valid), .out_ready(out_ready),
    .prob(prob), .out_idx(out_idx), .out_last(out_last), .div_zero(div_zero),
    .row_done(row_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] prob; int idx; } sb_item_t;
  sb_item_t sb[$];
  sb_item_t mon_item;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int model_idx = 0;
  int pop_cnt = 0;
  int last_cnt = 0;
  int row_done_cnt = 0;
  logic prev_last_pop = 1'b0;
  logic bp_rand = 1'b0;
  int lat;

  always @(posedge clk) cyc <= cyc + 1;

  // Exact reference: the quotient exp/sum in fixed point, by plain division.
  function automatic logic [15:0] ref_prob(input logic [31:0] e, input logic [31:0] s);
    longint unsigned num, q;
    if (s == 0) return 16'hFFFF;
    if (e == 0) return 16'h0000;
    if (e >= s) return 16'hFFFF;
`ifdef STAR_NORM_ROUND_EN
    num = longint'(e) << 17;
    q = ((num / longint'(s)) + 1) >> 1;
    if (q > 64'hFFFF) q = 64'hFFFF;
`else
    num = longint'(e) << 16;
    q = num / longint'(s);
`endif
    return q[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every popped head is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      prev_last_pop = 1'b0;
    end else begin
      if (row_done || prev_last_pop) check("row_done_pulse", row_done, prev_last_pop);
      if (row_done) row_done_cnt++;
      prev_last_pop = 1'b0;
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (out_last) last_cnt++;
        prev_last_pop = out_last;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output prob=%0h idx=%0d", prob, out_idx);
        end else begin
          mon_item = sb.pop_front();
          check("prob", prob, mon_item.prob);
          check("out_idx", out_idx, mon_item.idx);
          check("out_last", out_last, (mon_item.idx == N_ELEM - 1));
        end
      end
    end
  end

  // Randomised back-pressure when enabled.
  always @(posedge clk) begin
    if (bp_rand) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] e, input logic [31:0] s);
    bit got;
    got = 0;
    @(posedge clk); #1;
    exp_in = e; sum_in = s; in_valid = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{ref_prob(e, s), model_idx});
        model_idx = (model_idx + 1) % N_ELEM;
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic send_rand();
    logic [31:0] s, e;
    s = $urandom_range(1, 32'h7FFF_FFFF);
    case ($urandom_range(0, 7))
      0:       e = $urandom;
      1:       e = 0;
      default: e = $urandom % s;
    endcase
    send(e, s);
  endtask

  task automatic wait_out(output int l);
    l = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid) begin
        l = cyc - acc_cyc;
        break;
      end
    end
    if (l < 0) check("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 5000 && sb.size() != 0; t++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    model_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    row_done_cnt = 0;
    last_cnt = 0;
    pop_cnt = 0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_prob", prob, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_row_done", row_done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);

    // divide path latency and value
    out_ready = 1'b1;
    send(32'd1, 32'd4);
    wait_out(lat);
    check("div_latency", lat, DIV_LAT);
    check("one_quarter", prob, 16'h4000);
    check("first_idx", out_idx, 0);
    send(32'd2, 32'd3);
    wait_out(lat);
    check("two_thirds", prob, TWO_THIRDS);

    // fast paths
    send(32'd0, 32'd7);
    wait_out(lat);
    check("fast_latency", lat, 1);
    check("zero_exp", prob, 16'h0000);
    send(32'd5, 32'd5);
    wait_out(lat);
    check("equal_sat", prob, 16'hFFFF);
    check("div_zero_before", div_zero, 0);
    send(32'd9, 32'd0);
    wait_out(lat);
    check("sum_zero", prob, 16'hFFFF);
    check("div_zero_set", div_zero, 1);
    for (int i = 0; i < 12; i++) send_rand();
    drain();
    check("div_zero_sticky", div_zero, 1);

    // random traffic with random back-pressure
    bp_rand = 1'b1;
    for (int i = 0; i < 30; i++) send_rand();
    bp_rand = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // back-pressure: four held, fifth stuck in PUSH
    do_reset();
    check("div_zero_cleared", div_zero, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_rand();
    repeat (25) @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_idx", out_idx, 0);
    check("bp_no_pops", pop_cnt, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    check("bp_pop_count", pop_cnt, 5);

    // full row plus one: single last, single row_done, wrap to idx 0
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N_ELEM + 1; i++) send_rand();
    drain();
    check("row_last_count", last_cnt, 1);
    check("row_done_count", row_done_cnt, 1);
    check("row_pop_count", pop_cnt, N_ELEM + 1);

    // reset in the middle of a divide
    send(32'd100, 32'd300);
    repeat (8) @(posedge clk);
    #1;
    check("mid_div_busy", in_ready, 0);
    reset = 1'b0;
    sb.delete();
    model_idx = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_no_output", out_valid, 0);
    send(32'd3, 32'd8);
    wait_out(lat);
    check("post_rst_idx", out_idx, 0);
    check("post_rst_prob", prob, 16'h6000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
